// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers: default widths,
// control-field bit offsets and the buffer occupancy state encoding.
package cpu_pipe_pkg;

  localparam int DEF_DW     = 32;
  localparam int DEF_NW     = 4;
  localparam int DEF_CTRL_W = 16;

  // Bit offsets into the packed control field; multi-bit fields start at the offset.
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_REGDST    = 3;   // [1:0]
  localparam int CTRL_MEMTOREG  = 5;   // [1:0]
  localparam int CTRL_STORETYPE = 7;   // [1:0]
  localparam int CTRL_LOADTYPE  = 9;   // [2:0]
  localparam int CTRL_EXCCODE   = 12;  // [1:0]

  // Encoded as {mainValid, skidValid} so the state is read straight off the entry flops.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } bufStateT;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream/downstream valid-ready handshake bundle for one pipeline stage buffer.
interface pipe_stage_buf_if #(
  parameter int DW     = 32,
  parameter int NW     = 4,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [NW*DW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [NW*DW-1:0]  out_data;

  // Environment side: drives the incoming entry and the downstream ready.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_entry_reg.sv
// One buffer slot: valid flag plus control and payload, with load and clear-to-bubble.
module pipe_entry_reg #(
  parameter int DW     = 32,
  parameter int NW     = 4,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrlIn,
  input  logic [NW*DW-1:0]  dataIn,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [NW*DW-1:0]  data
);

  // NOTE: payload and ctrl are reset and cleared along with valid, so an empty slot
  // always holds an all-zero control word that cannot cause a downstream write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= ctrlIn;
      data  <= dataIn;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional skid slot (registered in_ready) and a saturating stall counter.
module pipe_stage_buf
  import cpu_pipe_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int NW     = DEF_NW,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_buf_if.slave   bus,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              mainV, skidV;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl, mainCtrlIn;
  logic [NW*DW-1:0]  mainData, skidData, mainDataIn;
  logic              mainLoad, mainClear, mainFromSkid, skidLoad, skidClear;
  logic              inXfer, outXfer;
  bufStateT          state;

  assign state   = bufStateT'({mainV, skidV});
  assign inXfer  = bus.in_valid & bus.in_ready;
  assign outXfer = mainV & bus.out_ready;

  // Next-state decode; the state register itself is the pair of entry valid flags.
  always_comb begin
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (flush) begin
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: mainLoad = inXfer;
        ST_FULL1: begin
          if (inXfer && outXfer) mainLoad  = 1'b1;
          else if (inXfer)       skidLoad  = 1'b1;
          else if (outXfer)      mainClear = 1'b1;
        end
        ST_FULL2: begin
          if (outXfer) begin
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidClear    = 1'b1;
          end
        end
        default: begin
          mainClear = 1'b1;
          skidClear = 1'b1;
        end
      endcase
    end
  end

  assign mainCtrlIn = mainFromSkid ? skidCtrl : bus.in_ctrl;
  assign mainDataIn = mainFromSkid ? skidData : bus.in_data;

  pipe_entry_reg #(.DW(DW), .NW(NW), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (mainLoad),
    .clear  (mainClear),
    .ctrlIn (mainCtrlIn),
    .dataIn (mainDataIn),
    .valid  (mainV),
    .ctrl   (mainCtrl),
    .data   (mainData)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(.DW(DW), .NW(NW), .CTRL_W(CTRL_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skidLoad),
        .clear  (skidClear),
        .ctrlIn (bus.in_ctrl),
        .dataIn (bus.in_data),
        .valid  (skidV),
        .ctrl   (skidCtrl),
        .data   (skidData)
      );
      assign bus.in_ready = ~skidV;
    end else begin : g_noskid
      assign skidV        = 1'b0;
      assign skidCtrl     = '0;
      assign skidData     = '0;
      assign bus.in_ready = ~mainV | bus.out_ready;
    end
  endgenerate

  assign bus.out_valid = mainV;
  assign bus.out_ctrl  = mainV ? mainCtrl : '0;
  assign bus.out_data  = mainV ? mainData : '0;
  assign occupancy     = {1'b0, mainV} + {1'b0, skidV};

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (mainV && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
